// File: rtl/prog_seq_detector_pkg.sv
// Shared defaults and mode encodings for the programmable serial sequence detector.
package prog_seq_detector_pkg;
  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;
  localparam logic MEALY       = 1'b0;
  localparam logic MOORE       = 1'b1;
endpackage

// File: rtl/prog_seq_detector_if.sv
// Bit-stream, pattern-programming and result signals of the sequence detector.
interface prog_seq_detector_if
  import prog_seq_detector_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);
  // No backpressure: x is consumed in every cycle where x_valid=1.
  logic             x;
  logic             x_valid;
  logic [PAT_W-1:0] pattern;
  logic             pat_load;
  logic             overlap_en;
  logic             moore_mode;
  logic             z;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output x, x_valid, pattern, pat_load, overlap_en, moore_mode,
    input  z, match_count, count_sat
  );

  modport slave (
    input  x, x_valid, pattern, pat_load, overlap_en, moore_mode,
    output z, match_count, count_sat
  );
endinterface

// File: rtl/prog_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter
  import prog_seq_detector_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         sat_o
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)                        count_d = '0;
    else if (inc_i && count_q != MAX) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign sat_o   = (count_q == MAX);
endmodule

// File: rtl/prog_seq_detector.sv
// Programmable serial pattern detector: Mealy/Moore output, optional overlap, saturating match count.
module prog_seq_detector
  import prog_seq_detector_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  prog_seq_detector_if.slave bus
);
  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q, hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_q;
  logic              match;
  logic [CNT_W-1:0]  count;
  logic              sat;

  // A bit arriving together with pat_load is dropped, so it cannot match either.
  assign match = bus.x_valid && !bus.pat_load && (fill_q >= FILL_THR) &&
                 ({hist_q[PAT_W-2:0], bus.x} == pat_q);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.x_valid) begin
      hist_d = {hist_q[PAT_W-2:0], bus.x};
      if (match && bus.overlap_en != OVERLAP) fill_d = '0;
      else if (fill_q != FILL_FULL)           fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '1;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else if (bus.pat_load) begin
      pat_q  <= bus.pattern;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= match;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (bus.pat_load),
    .inc_i   (match),
    .count_o (count),
    .sat_o   (sat)
  );

  // Outputs are forced low while reset is held, before the registers have cleared.
  assign bus.z           = !reset && ((bus.moore_mode == MOORE) ? z_q : match);
  assign bus.match_count = reset ? '0 : count;
  assign bus.count_sat   = !reset && sat;
endmodule
